// File: rtl/ora_misr_session_pkg.sv
// -----------------------------------------------------------------------------
// ora_pkg
// Shared definitions for the MISR output response analyser:
//   - state_e : session controller states (IDLE / COMPACT / COMPARE)
//   - POLY4/POLY8/POLY16 : common primitive feedback polynomials, bit i is the
//     coefficient of x^i with the x^WIDTH term implicit.
// -----------------------------------------------------------------------------
package ora_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        COMPARE = 2'd2
    } state_e;

    localparam logic [3:0]  POLY4  = 4'b0011;    // x^4  + x + 1
    localparam logic [7:0]  POLY8  = 8'h1D;      // x^8  + x^4 + x^3 + x^2 + 1
    localparam logic [15:0] POLY16 = 16'h002D;   // x^16 + x^5 + x^3 + x^2 + 1

endpackage

// File: rtl/ora_misr_session_if.sv
// -----------------------------------------------------------------------------
// ora_misr_session_if
// Session and response bus of the output response analyser.
//   start/pattern_count/golden : session request from the BIST controller
//   data_valid/datain          : CUT response word stream
//   signature/busy/done/pass   : analyser status and verdict
// Modports: master drives requests and responses, slave is the analyser.
// -----------------------------------------------------------------------------
interface ora_misr_session_if #(
    parameter int WIDTH    = 4,
    parameter int IN_WIDTH = 2,
    parameter int CNT_W    = 8
) ();

    logic                start;
    logic [CNT_W-1:0]    pattern_count;
    logic [WIDTH-1:0]    golden;
    logic                data_valid;
    logic [IN_WIDTH-1:0] datain;
    logic [WIDTH-1:0]    signature;
    logic                busy;
    logic                done;
    logic                pass;

    modport master (
        output start, pattern_count, golden, data_valid, datain,
        input  signature, busy, done, pass
    );

    modport slave (
        input  start, pattern_count, golden, data_valid, datain,
        output signature, busy, done, pass
    );

endinterface

// File: rtl/ora_misr_session_misr_core.sv
// -----------------------------------------------------------------------------
// misr_core
// Galois-form multiple-input signature register. Each enabled cycle computes
//   sig <- sig * x + din  (mod P(x)),  P(x) = x^WIDTH + POLY
// with din zero-extended to WIDTH bits.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset, loads SEED
//   load   : synchronous reload of SEED (has priority over enable)
//   enable : compact din into the signature this cycle
//   din    : response word, IN_WIDTH bits
//   sig    : registered signature
// -----------------------------------------------------------------------------
module misr_core #(
    parameter int               WIDTH    = 4,
    parameter int               IN_WIDTH = 2,
    parameter logic [WIDTH-1:0] POLY     = 4'b0011,
    parameter logic [WIDTH-1:0] SEED     = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic                enable,
    input  logic [IN_WIDTH-1:0] din,
    output logic [WIDTH-1:0]    sig
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [WIDTH-1:0] din_ext;
    logic [WIDTH-1:0] feedback;
    logic             msb;

    assign msb     = sig_q[WIDTH-1];
    assign din_ext = WIDTH'(din);

    // Bit 0 always takes the MSB back; higher taps follow POLY.
    assign feedback = {POLY[WIDTH-1:1] & {(WIDTH-1){msb}}, msb};

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (enable) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ feedback ^ din_ext;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/ora_misr_session.sv
// -----------------------------------------------------------------------------
// ora_misr_session
// MISR output response analyser with a test-session controller. A session is
// opened by start in IDLE, compacts pattern_count response words (stalling
// while data_valid is low), then compares the signature against golden and
// pulses done with the verdict on pass.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset; aborts a session without done
//   bus   : ora_misr_session_if.slave
//           start/pattern_count/golden in, data_valid/datain in,
//           signature/busy/done/pass out (all registered)
// -----------------------------------------------------------------------------
module ora_misr_session
    import ora_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter int               IN_WIDTH = 2,
    parameter logic [WIDTH-1:0] POLY     = POLY4,
    parameter logic [WIDTH-1:0] SEED     = '0,
    parameter int               CNT_W    = 8
) (
    input  logic                clock,
    input  logic                reset,
    ora_misr_session_if.slave   bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [WIDTH-1:0]   golden_q, golden_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic               misr_load;
    logic               misr_enable;
    logic [WIDTH-1:0]   sig;

    misr_core #(
        .WIDTH    (WIDTH),
        .IN_WIDTH (IN_WIDTH),
        .POLY     (POLY),
        .SEED     (SEED)
    ) u_misr (
        .clock  (clock),
        .reset  (reset),
        .load   (misr_load),
        .enable (misr_enable),
        .din    (bus.datain),
        .sig    (sig)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        target_d    = target_q;
        golden_d    = golden_q;
        pass_d      = pass_q;
        misr_load   = 1'b0;
        misr_enable = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    misr_load = 1'b1;
                    target_d  = bus.pattern_count;
                    golden_d  = bus.golden;
                    cnt_d     = '0;
                    pass_d    = 1'b0;
                    state_d   = (bus.pattern_count == '0) ? COMPARE : COMPACT;
                end
            end
            COMPACT: begin
                if (bus.data_valid) begin
                    misr_enable = 1'b1;
                    // Exit on equality: the counter never needs to pass the
                    // target, so it cannot wrap even at the maximum count.
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == target_q) begin
                        state_d = COMPARE;
                    end
                end
            end
            COMPARE: begin
                // The signature is stable here: the last word landed on the
                // edge that entered this state.
                pass_d  = (sig == golden_q);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == COMPARE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            golden_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            golden_q <= golden_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign bus.signature = sig;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;

endmodule
